mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; a responder on the core's data bus alongside the SRAM.

---
 rtl/mmio_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divisor, pollable status.
// Responds to the core's data bus in a 16-byte window at BASE_ADDR.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic        data_sign,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_read_data,
  output logic        hit,
  output logic        uart_tx
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [15:0]      baud_cnt;
  logic [15:0]      divisor;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic [1:0]  offset;
  logic        rd_hit;
  logic        wr_hit;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic        bit_end;
  logic        pop;
  logic        push_req;
  logic        push;
  logic [31:0] status_word;
  logic [31:0] reg_word;
  logic        unused_wdata;

  // Right-justify the addressed lane, then truncate and extend to the access size.
  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic sign_ext, input logic [1:0] lane);
    logic [31:0]        shifted;
    logic signed [31:0] ext;
    shifted = word >> {lane, 3'b000};
    case (size)
      2'd0:    ext = sign_ext ? $signed({{24{shifted[7]}}, shifted[7:0]})
                              : $signed({24'd0, shifted[7:0]});
      2'd1:    ext = sign_ext ? $signed({{16{shifted[15]}}, shifted[15:0]})
                              : $signed({16'd0, shifted[15:0]});
      default: ext = $signed(word);
    endcase
    return ext;
  endfunction

  assign hit          = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign offset       = data_addr[3:2];
  assign rd_hit       = data_read & hit;
  assign wr_hit       = data_write & hit;
  assign fifo_full    = (count == DEPTH_CNT);
  assign fifo_empty   = (count == '0);
  assign busy         = (state != IDLE);
  assign bit_end      = (baud_cnt == 16'd0);
  assign unused_wdata = ^data_write_data[31:16];

  // The transmitter takes the head byte when idle or exactly as a stop bit ends.
  assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign push_req = wr_hit && (offset == 2'd0);
  assign push     = push_req && (!fifo_full || pop);

  assign status_word = {16'd0, 8'(count), 4'd0, overflow, busy, fifo_empty, fifo_full};

  always_comb begin
    reg_word = '0;
    case (offset)
      2'd1:    reg_word = status_word;
      2'd2:    reg_word = {16'd0, divisor};
      default: reg_word = '0;
    endcase
  end

  // Bus side: registered load data, FIFO pointers, sticky overflow, divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_read_data <= '0;
      divisor        <= DEFAULT_DIV;
      overflow       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else begin
      if (rd_hit)
        data_read_data <= format_load(reg_word, data_size, data_sign, data_addr[1:0]);
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A dropped byte in the same cycle as a STATUS read must still be reported.
      if (push_req && !push)
        overflow <= 1'b1;
      else if (rd_hit && offset == 2'd1)
        overflow <= 1'b0;
      if (wr_hit && offset == 2'd2) begin
        if (data_size == 2'd0)
          divisor[7:0] <= data_write_data[7:0];
        else
          divisor <= data_write_data[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= data_write_data[7:0];
    if (pop)
      shift_reg <= fifo_mem[rd_ptr];
  end

  // Line side: every bit boundary reloads the counter from the current divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            state    <= START;
            baud_cnt <= divisor;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= divisor;
            bit_idx  <= 3'd0;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= divisor;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= divisor;
            if (pop) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model compared every cycle, directed pins, random bus traffic.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic        data_sign = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_write_data = 32'd0;
  logic [31:0] data_read_data;
  logic        hit;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd3)) dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
    .data_sign(data_sign), .data_size(data_size), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_read_data(data_read_data),
    .hit(hit), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, divisor, sticky flag, and the frame currently on the line
  // expressed as a 10-entry bit array with a position and cycles left in that bit.
  logic [7:0]  mq[$];
  logic [15:0] m_div = 16'd3;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_active = 1'b0;
  logic [9:0]  m_frame = 10'h3FF;
  int          m_pos = 0;
  int          m_left = 0;

  function automatic logic [31:0] m_format(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lane);
    longint v;
    if (sz == 2'd0) begin
      v = longint'(word >> (8 * lane)) % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'(word >> (8 * lane)) % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(word);
    end
    return 32'(v);
  endfunction

  always @(posedge clk) begin : model
    logic        mhit;
    logic [1:0]  off;
    logic        do_pop;
    logic [7:0]  head;
    logic [31:0] regv;
    int          cnt;
    if (rst) begin
      mq.delete();
      m_div = 16'd3;
      m_ovf = 1'b0;
      m_rdata = 32'd0;
      m_active = 1'b0;
      m_pos = 0;
      m_left = 0;
    end else begin
      mhit = (data_addr[31:4] == BASE[31:4]);
      off = data_addr[3:2];
      cnt = mq.size();
      if (data_read && mhit) begin
        regv = 32'd0;
        if (off == 2'd1)
          regv = 32'(cnt * 256 + int'(m_ovf) * 8 + int'(m_active) * 4 + int'(cnt == 0) * 2 + int'(cnt == DEPTH));
        else if (off == 2'd2)
          regv = 32'(m_div);
        m_rdata = m_format(regv, data_size, data_sign, data_addr[1:0]);
        if (off == 2'd1) m_ovf = 1'b0;
      end
      do_pop = 1'b0;
      if (!m_active) begin
        do_pop = (cnt > 0);
      end else if (m_left > 1) begin
        m_left--;
      end else if (m_pos < 9) begin
        m_pos++;
        m_left = int'(m_div) + 1;
      end else begin
        m_active = 1'b0;
        do_pop = (cnt > 0);
      end
      if (do_pop) begin
        head = mq.pop_front();
        m_frame = {1'b1, head, 1'b0};
        m_pos = 0;
        m_left = int'(m_div) + 1;
        m_active = 1'b1;
      end
      if (data_write && mhit) begin
        if (off == 2'd0) begin
          if (mq.size() < DEPTH) mq.push_back(data_write_data[7:0]);
          else m_ovf = 1'b1;
        end else if (off == 2'd2) begin
          if (data_size == 2'd0) m_div[7:0] = data_write_data[7:0];
          else m_div = data_write_data[15:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      expect_eq("uart_tx", 32'(uart_tx), 32'(m_active ? m_frame[m_pos] : 1'b1));
      expect_eq("read_data", data_read_data, m_rdata);
      expect_eq("hit", 32'(hit), 32'(data_addr[31:4] == BASE[31:4]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    data_addr = a;
    data_write_data = d;
    data_size = sz;
    data_write = 1'b1;
    tick();
    data_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    data_addr = a;
    data_size = sz;
    data_sign = sg;
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || mq.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s drain timeout actual=%0d cycles required<3000", name, n);
    end
  endtask

  initial begin
    logic [9:0] fr;
    // Reset and idle
    rst = 1'b1;
    repeat (3) tick();
    expect_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    expect_eq("rst_read_data", data_read_data, 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    expect_eq("idle_uart_tx", 32'(uart_tx), 32'd1);
    expect_eq("idle_read_data", data_read_data, 32'd0);
    bus_read(BASE + 32'h4, 2'd2, 1'b0);
    expect_eq("idle_status", data_read_data, 32'h0000_0002);

    // Single frame 0xA5 at 4 cycles per bit
    bus_write(BASE, 32'h0000_00A5, 2'd2);
    expect_eq("a5_before_start", 32'(uart_tx), 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      tick();
      expect_eq("a5_frame_bit", 32'(uart_tx), 32'(fr[i / 4]));
    end
    tick();
    bus_read(BASE + 32'h4, 2'd2, 1'b0);
    expect_eq("a5_status_done", data_read_data, 32'h0000_0002);

    // Back-to-back writes overflow the FIFO; STATUS read clears the sticky flag
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'($urandom_range(0, 255)), 2'd0);
    bus_read(BASE + 32'h4, 2'd2, 1'b0);
    expect_eq("ovf_status1", data_read_data, 32'h0000_080D);
    bus_read(BASE + 32'h4, 2'd2, 1'b0);
    expect_eq("ovf_status2", data_read_data, 32'h0000_0805);
    wait_idle("burst");

    // Divisor change mid-frame; byte read of divisor upper lane
    bus_write(BASE, 32'h0000_003C, 2'd2);
    repeat (9) tick();
    bus_write(BASE + 32'h8, 32'h0000_0001, 2'd2);
    bus_read(BASE + 32'h9, 2'd0, 1'b1);
    expect_eq("div1_byte9", data_read_data, 32'h0000_0000);
    wait_idle("div1");

    // Load formatting on DIVISOR
    bus_write(BASE + 32'h8, 32'h0000_80F0, 2'd1);
    bus_read(BASE + 32'h8, 2'd1, 1'b1);
    expect_eq("half_signed", data_read_data, 32'hFFFF_80F0);
    bus_read(BASE + 32'h8, 2'd1, 1'b0);
    expect_eq("half_unsigned", data_read_data, 32'h0000_80F0);
    bus_read(BASE + 32'h9, 2'd0, 1'b1);
    expect_eq("byte9_signed", data_read_data, 32'hFFFF_FF80);
    bus_write(BASE + 32'h8, 32'h1234_5603, 2'd0);
    bus_read(BASE + 32'h8, 2'd3, 1'b1);
    expect_eq("div_byte_write", data_read_data, 32'h0000_8003);
    bus_write(BASE + 32'h8, 32'h0000_0003, 2'd2);

    // Reset during DATA bit 3 with bytes still queued
    bus_write(BASE, 32'h0000_005A, 2'd0);
    bus_write(BASE, 32'h0000_00C3, 2'd0);
    bus_write(BASE, 32'h0000_0011, 2'd0);
    repeat (16) tick();
    rst = 1'b1;
    #1;
    expect_eq("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
    expect_eq("rst_mid_read_data", data_read_data, 32'd0);
    tick();
    rst = 1'b0;
    bus_read(BASE + 32'h4, 2'd2, 1'b0);
    expect_eq("rst_mid_status", data_read_data, 32'h0000_0002);
    bus_read(BASE + 32'h8, 2'd2, 1'b0);
    expect_eq("rst_mid_div", data_read_data, 32'h0000_0003);
    data_addr = BASE + 32'h10;
    #1;
    expect_eq("miss_hit", 32'(hit), 32'd0);
    bus_write(BASE + 32'h10, 32'h0000_0077, 2'd2);
    bus_write(BASE + 32'h18, 32'h0000_0000, 2'd2);
    bus_read(BASE + 32'h14, 2'd2, 1'b0);
    expect_eq("miss_read_hold", data_read_data, 32'h0000_0003);
    repeat (4) tick();
    expect_eq("miss_uart_idle", 32'(uart_tx), 32'd1);
    bus_read(BASE + 32'h8, 2'd2, 1'b0);
    expect_eq("miss_div_kept", data_read_data, 32'h0000_0003);

    // Random bus traffic; divisor kept at 0..3 so frames stay short
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      data_read = 1'b0;
      data_write = 1'b0;
      data_addr = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) data_addr = data_addr + 32'h10;
      data_size = 2'($urandom_range(0, 3));
      data_sign = 1'($urandom_range(0, 1));
      data_write_data = (data_addr[3:2] == 2'd2) ? 32'($urandom_range(0, 3)) : $urandom;
      if (r < 8) data_write = 1'b1;
      else if (r < 20) data_read = 1'b1;
      else if (r < 23) begin
        data_read = 1'b1;
        data_write = 1'b1;
      end
      tick();
    end
    data_read = 1'b0;
    data_write = 1'b0;
    wait_idle("random");
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
